sub_bytes_scheduler: RTL
========================

Name: sub_bytes_scheduler

Overview:
Sequences the SubBytes stage of the CLM cipher over a configurable number of S-box instances.
- Captures the 16-byte redundant state.
- Issues NUM_SB bytes per group to the sbox instances, collects their per-lane completions, and assembles the substituted state.
- Signals completion to the top-level stage FSM.
- With `CHEAP_SB (NUM_SB=4), four groups are time-multiplexed. With NUM_SB=16, one group is issued.

Parameters:
D, 8, redundancy width; state_t is 8+D bits, red_poly_t is D bits.
NUM_SB, 4, sbox instances driven; legal values 1, 2, 4, 8, 16.
GROUPS, 16/NUM_SB, derived; number of issue groups.

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
active  input  1  level; start request from the stage FSM
load_r  input  1  latch random_vect (honoured in SBS_IDLE/SBS_HOLD only)
in  input  16*(8+D)  state_vec_t, state to substitute
random_vect  input  7*D  red_poly_t[0:6], masking randomness
out  output  16*(8+D)  state_vec_t, substituted state
drdy_o  output  1  one-cycle completion pulse
sb_in  output  NUM_SB*(8+D)  per-lane sbox input
sb_r  output  NUM_SB*7*D  per-lane randomness
sb_drdy_i  output  1  issue pulse, shared by all lanes
sb_drdy_o  input  NUM_SB  per-lane sbox completion

Behaviour:
Interface: one clock (clk); rst is asynchronous and active-high; all state registers clear on rst assertion.

Reset values:
- out=0, drdy_o=0, sb_drdy_i=0, sb_in=0.
- Latched r=0; group counter=0; done flags=0.
- State=SBS_IDLE.

Byte indexing:
- flat index f = 4*i + j for in[i][j].
- Lane k of group g processes f = g*NUM_SB + k.

Randomness:
- r_q is latched from random_vect when load_r=1 in SBS_IDLE or SBS_HOLD.
- load_r is ignored in all other states; r_q stays constant for the whole run.
- Lane k element e receives r_q[(e+k) mod 7].

FSM (sbs_stage_t):
- SBS_IDLE: if active=1, capture in into buf_q, set g=0, go to SBS_ISSUE.
- SBS_ISSUE:
  - sb_in = buf_q bytes of group g.
  - sb_drdy_i=1 for exactly this cycle.
  - Clear done flags; go to SBS_WAIT.
- SBS_WAIT:
  - For each lane with sb_drdy_o[k]=1, latch sb_out[k] into res_q slot and set done[k].
  - When (done | sb_drdy_o) is all ones:
    - if g==GROUPS-1, go to SBS_DONE;
    - else g++ and go to SBS_ISSUE.
  - Lanes may complete in different cycles. A repeated sb_drdy_o on a lane already done is ignored; the first value is kept.
  - sb_in is held stable throughout SBS_WAIT.
- SBS_DONE: out <= res_q (registered), drdy_o=1 this cycle only, go to SBS_HOLD.
- SBS_HOLD: stay until active=0, then go to SBS_IDLE. A still-high active never starts a second run.

sb_out:
- Per-lane sbox result, NUM_SB*(8+D) bits.
- It is an additional input port: sb_out input NUM_SB*(8+D).

Latency:
- Assume a sbox that raises drdy_o L cycles after drdy_i, and active sampled at cycle 0.
- The first ISSUE is at cycle 1.
- drdy_o is high at cycle 1 + GROUPS*(L+1).
- out is valid from the cycle after drdy_o and held until the next SBS_DONE.

Abort:
- active=0 in SBS_ISSUE or SBS_WAIT returns the FSM to SBS_IDLE next cycle.
- No drdy_o is produced and out is unchanged.
- Late sb_drdy_o in SBS_IDLE is ignored.

Reset mid-run: the FSM returns to SBS_IDLE immediately; out is cleared.

Decomposition:
Shared types package additions:
- enum sbs_stage_t {SBS_IDLE, SBS_ISSUE, SBS_WAIT, SBS_DONE, SBS_HOLD} with `SBS_BITS 3.
- `NUM_SB derived from `CHEAP_SB (4 or 16).

Sub-module sbs_lane_collector, one per lane:
- Holds the done flag and result register.
- Clears on issue; captures on the first sb_drdy_o.

Test Plan:
1. Full run: NUM_SB=4, sbox model with L=7, in = bytes 0x00..0x0F with zero redundancy -> drdy_o pulses exactly at cycle 33; out[f] = model(f) for all 16 bytes; sb_drdy_i pulses at cycles 1, 9, 17, 25.
2. Full run: NUM_SB=16, L=7 -> single sb_drdy_i at cycle 1, drdy_o at cycle 9.
3. Skewed completion: lane 2 completes 3 cycles after the other lanes in group 1 -> group 2 issues only after lane 2; all results correct; drdy_o delayed by 3 cycles.
4. Randomness: load_r with random_vect = elements 0x01..0x07 in SBS_IDLE, then load_r=1 with 0xFF during SBS_WAIT -> lane 1 elements equal 0x02, 0x03, ..., 0x07, 0x01 throughout the run; the 0xFF load is ignored.
5. Abort: active drops during group 2 SBS_WAIT -> no drdy_o; out keeps the prior result; the next run completes normally.
6. Reset: rst asserted asynchronously mid-WAIT -> out=0, drdy_o=0, sb_drdy_i=0 in the same cycle; held active=1 after rst release starts a fresh run. Separately, active held high after drdy_o yields no second drdy_o.

Source files
------------

// File: rtl/sub_bytes_scheduler_pkg.sv
// Shared types for the SubBytes scheduler: stage encoding, sizing constants and
// the lane-to-randomness rotation helper.
package sub_bytes_scheduler_pkg;

    localparam int SBS_BITS        = 3;
    localparam int SBS_STATE_BYTES = 16;
    localparam int SBS_RAND_ELEMS  = 7;

    // Lane count a top-level build should pass in; the cheap build time-multiplexes four sboxes.
`ifdef CHEAP_SB
    localparam int SBS_NUM_SB = 4;
`else
    localparam int SBS_NUM_SB = 16;
`endif

    typedef enum logic [SBS_BITS-1:0] {
        SBS_IDLE,
        SBS_ISSUE,
        SBS_WAIT,
        SBS_DONE,
        SBS_HOLD
    } sbs_stage_t;

    // Each lane sees the latched randomness rotated by its lane number.
    function automatic int sbs_rand_sel(input int elem, input int lane);
        return (elem + lane) % SBS_RAND_ELEMS;
    endfunction

endpackage

// File: rtl/sub_bytes_scheduler_lane_collector.sv
// Per-lane completion tracker: remembers whether the lane's sbox has answered in
// the current group and keeps the first answer it gave.
module sbs_lane_collector
    import sub_bytes_scheduler_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic         lane_drdy,
    input  logic [W-1:0] lane_data,
    output logic         done,
    output logic [W-1:0] value
);

    logic         done_q;
    logic [W-1:0] result_q;
    logic         capture;

    // Only the first completion of a group is taken; repeats are dropped.
    assign capture = enable & lane_drdy & ~done_q;
    assign done    = done_q;
    assign value   = capture ? lane_data : result_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (clear) begin
            done_q   <= 1'b0;
        end else if (capture) begin
            done_q   <= 1'b1;
            result_q <= lane_data;
        end
    end

endmodule

// File: rtl/sub_bytes_scheduler.sv
// SubBytes stage sequencer: feeds the 16-byte state to NUM_SB sbox lanes one
// group at a time and assembles the substituted state.
module sub_bytes_scheduler
    import sub_bytes_scheduler_pkg::*;
#(
    parameter int D      = 8,
    parameter int NUM_SB = 4
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     active,
    input  logic                                     load_r,
    input  logic [SBS_STATE_BYTES*(8+D)-1:0]         in,
    input  logic [SBS_RAND_ELEMS*D-1:0]              random_vect,
    output logic [SBS_STATE_BYTES*(8+D)-1:0]         out,
    output logic                                     drdy_o,
    output logic [NUM_SB*(8+D)-1:0]                  sb_in,
    output logic [NUM_SB*SBS_RAND_ELEMS*D-1:0]       sb_r,
    output logic                                     sb_drdy_i,
    input  logic [NUM_SB-1:0]                        sb_drdy_o,
    input  logic [NUM_SB*(8+D)-1:0]                  sb_out
);

    localparam int W      = 8 + D;
    localparam int NB     = SBS_STATE_BYTES;
    localparam int GROUPS = NB / NUM_SB;
    localparam int GB     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

    sbs_stage_t                       state;
    logic [GB-1:0]                    g;
    logic [NB*W-1:0]                  buf_q;
    logic [NB*W-1:0]                  res_q;
    logic [SBS_RAND_ELEMS*D-1:0]      r_q;
    logic [NUM_SB-1:0]                done_vec;
    logic [NUM_SB*W-1:0]              lane_val;
    logic                             lane_clear;
    logic                             lane_enable;
    logic                             group_done;
    logic                             last_group;

    assign lane_clear  = (state == SBS_ISSUE);
    assign lane_enable = (state == SBS_WAIT);
    assign group_done  = &(done_vec | sb_drdy_o);
    assign last_group  = (int'(g) == GROUPS - 1);

    genvar k, e;
    generate
        for (k = 0; k < NUM_SB; k++) begin : g_lane
            sbs_lane_collector #(.W(W)) u_collector (
                .clk       (clk),
                .rst       (rst),
                .clear     (lane_clear),
                .enable    (lane_enable),
                .lane_drdy (sb_drdy_o[k]),
                .lane_data (sb_out[k*W +: W]),
                .done      (done_vec[k]),
                .value     (lane_val[k*W +: W])
            );
            for (e = 0; e < SBS_RAND_ELEMS; e++) begin : g_rand
                assign sb_r[(k*SBS_RAND_ELEMS + e)*D +: D] = r_q[sbs_rand_sel(e, k)*D +: D];
            end
        end
    endgenerate

    // Stage FSM; sb_in and sb_drdy_i are loaded on the transition into ISSUE so
    // the sboxes see a registered, glitch-free issue beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= SBS_IDLE;
            g         <= '0;
            buf_q     <= '0;
            res_q     <= '0;
            r_q       <= '0;
            out       <= '0;
            drdy_o    <= 1'b0;
            sb_drdy_i <= 1'b0;
            sb_in     <= '0;
        end else begin
            drdy_o    <= 1'b0;
            sb_drdy_i <= 1'b0;

            if (load_r && (state == SBS_IDLE || state == SBS_HOLD)) begin
                r_q <= random_vect;
            end

            case (state)
                SBS_IDLE: begin
                    if (active) begin
                        buf_q     <= in;
                        sb_in     <= in[NUM_SB*W-1:0];
                        g         <= '0;
                        sb_drdy_i <= 1'b1;
                        state     <= SBS_ISSUE;
                    end
                end
                SBS_ISSUE: begin
                    state <= active ? SBS_WAIT : SBS_IDLE;
                end
                SBS_WAIT: begin
                    if (!active) begin
                        state <= SBS_IDLE;
                    end else if (group_done) begin
                        for (int i = 0; i < NUM_SB; i++) begin
                            res_q[(int'(g)*NUM_SB + i)*W +: W] <= lane_val[i*W +: W];
                        end
                        if (last_group) begin
                            drdy_o <= 1'b1;
                            state  <= SBS_DONE;
                        end else begin
                            for (int i = 0; i < NUM_SB; i++) begin
                                sb_in[i*W +: W] <= buf_q[(((int'(g) + 1)*NUM_SB + i) % NB)*W +: W];
                            end
                            g         <= g + GB'(1);
                            sb_drdy_i <= 1'b1;
                            state     <= SBS_ISSUE;
                        end
                    end
                end
                SBS_DONE: begin
                    out   <= res_q;
                    state <= SBS_HOLD;
                end
                SBS_HOLD: begin
                    if (!active) begin
                        state <= SBS_IDLE;
                    end
                end
                default: begin
                    state <= SBS_IDLE;
                end
            endcase
        end
    end

endmodule
